// File: rtl/count_cmd_seq.sv
// count_cmd_seq: command sequencer for the up/down load counter (LOAD, RUN_UP/RUN_DOWN for N cycles, NOP).
// Latency: handshake at edge T, first active cycle T+1, o_done in the cycle after the last active one.
// Backpressure: o_cmd_ready while idle; COUNT_CMD_SEQ_SKID_EN adds a one-entry buffer accepting while active.
module count_cmd_seq #(
    parameter int DATA_WIDTH = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n_async,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [1:0]            i_cmd_op,
    input  logic [DATA_WIDTH-1:0] i_cmd_val,
    input  logic [LEN_WIDTH-1:0]  i_cmd_len,
    output logic                  o_up,
    output logic                  o_load,
    output logic [DATA_WIDTH-1:0] o_load_val,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   remaining;
    logic                   active;
    logic                   last;
    logic                   hs;

    logic                   nxt_vld;
    logic [1:0]             nxt_op;
    logic [DATA_WIDTH-1:0]  nxt_val;
    logic [LEN_WIDTH-1:0]   nxt_len;
    logic                   nxt_run;
    logic                   nxt_act;
    logic                   nxt_zero;

    assign active = (state != ST_IDLE);
    assign last   = (state == ST_LOAD) ||
                    ((state == ST_RUN) && (remaining == LEN_WIDTH'(1)));

`ifdef COUNT_CMD_SEQ_SKID_EN
    logic                   buf_vld;
    logic [1:0]             buf_op;
    logic [DATA_WIDTH-1:0]  buf_val;
    logic [LEN_WIDTH-1:0]   buf_len;
    // a buffered zero-length command still owes its own o_done pulse
    logic                   done_pend;

    assign o_cmd_ready = !active || !buf_vld;
`else
    assign o_cmd_ready = !active;
`endif

    assign hs = i_cmd_valid && o_cmd_ready;

    // Command to launch at this edge: a fresh handshake while idle, or,
    // on the last active cycle, the buffered (or just-offered) command.
    always_comb begin
        nxt_vld = 1'b0;
        nxt_op  = i_cmd_op;
        nxt_val = i_cmd_val;
        nxt_len = i_cmd_len;
        if (!active) begin
            nxt_vld = hs;
`ifdef COUNT_CMD_SEQ_SKID_EN
        end else if (last) begin
            if (buf_vld) begin
                nxt_vld = 1'b1;
                nxt_op  = buf_op;
                nxt_val = buf_val;
                nxt_len = buf_len;
            end else begin
                nxt_vld = hs;
            end
`endif
        end
    end

    assign nxt_run  = (nxt_op == OP_UP) || (nxt_op == OP_DOWN);
    assign nxt_act  = nxt_vld && ((nxt_op == OP_LOAD) || (nxt_run && (nxt_len != '0)));
    assign nxt_zero = nxt_vld && !nxt_act;

    always_ff @(posedge i_clk or negedge i_reset_n_async) begin
        if (!i_reset_n_async) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            o_up       <= 1'b1;
            o_load     <= 1'b0;
            o_load_val <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_load <= 1'b0;
            o_done <= 1'b0;
            if (state == ST_RUN) begin
                remaining <= remaining - LEN_WIDTH'(1);
            end
            if (active && last) begin
                state  <= ST_IDLE;
                o_busy <= 1'b0;
                o_done <= 1'b1;
            end
            if (nxt_act) begin
                o_busy <= 1'b1;
                if (nxt_op == OP_LOAD) begin
                    state      <= ST_LOAD;
                    o_load     <= 1'b1;
                    o_load_val <= nxt_val;
                end else begin
                    state     <= ST_RUN;
                    o_up      <= (nxt_op == OP_UP);
                    remaining <= nxt_len;
                end
            end else if (nxt_zero && !active) begin
                o_done <= 1'b1;
            end
`ifdef COUNT_CMD_SEQ_SKID_EN
            if (!active && done_pend) begin
                o_done <= 1'b1;
            end
`endif
        end
    end

`ifdef COUNT_CMD_SEQ_SKID_EN
    always_ff @(posedge i_clk or negedge i_reset_n_async) begin
        if (!i_reset_n_async) begin
            buf_vld   <= 1'b0;
            buf_op    <= OP_NOP;
            buf_val   <= '0;
            buf_len   <= '0;
            done_pend <= 1'b0;
        end else begin
            if (active && last) begin
                buf_vld <= 1'b0;
            end else if (active && hs) begin
                buf_vld <= 1'b1;
                buf_op  <= i_cmd_op;
                buf_val <= i_cmd_val;
                buf_len <= i_cmd_len;
            end
            // a zero-length command finishing on the heels of another keeps the pending pulse alive
            if (!active) begin
                done_pend <= done_pend && nxt_zero;
            end else if (nxt_zero) begin
                done_pend <= 1'b1;
            end
        end
    end
`endif

endmodule
